pipe_hazard_ctrl: RTL

Hazard and stall controller for the five-stage dynamic pipeline. It sits beside the ID stage and decides each cycle whether the PC and IF/ID registers may load (`nostall`) and whether a bubble goes into ID/EX. It covers three sources of stall: load-use hazards, D-stage branch operand hazards, and HI/LO dependencies on the multicycle multiply/divide unit, which it sequences with an internal busy counter. It also keeps a stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/mdu_seq.sv | 73 +++++++
 rtl/pipe_hazard_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-number width, the MDU sequencer
// state encoding and the hard-wired zero register.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_num_t;

    localparam reg_num_t REG_ZERO = '0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide occupancy sequencer: tracks how long the MDU is busy,
// restarts on a back-to-back issue and pulses md_done_o when HI/LO is written.
module mdu_seq
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    input  logic md_div_i,
    output logic md_busy_o,
    output logic md_done_o,
    output logic md_pending_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal; otherwise
    // synthesis infers latches for the unassigned branches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_div_i ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                // A new issue abandons the running operation and its result.
                if (md_start_i) begin
                    cnt_d = md_div_i ? DIV_LOAD : MUL_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        md_busy_o    = (state_q == MD_BUSY);
        md_pending_o = (state_q == MD_BUSY) && (cnt_q != '0);
        md_done_d    = (state_q == MD_BUSY) && (cnt_q == '0) && !md_start_i;
        md_done_o    = md_done_q;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: load-use, branch-operand and HI/LO stalls,
// flush priority, and a free-running stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             d_is_branch,
    input  logic             d_use_hilo,
    input  logic [REG_W-1:0] e_wreg,
    input  logic             e_regwrite,
    input  logic             e_memread,
    input  logic [REG_W-1:0] m_wreg,
    input  logic             m_memread,
    input  logic             e_md_start,
    input  logic             e_md_div,
    input  logic             ex_flush,
    output logic             nostall,
    output logic             d_flush,
    output logic             e_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [31:0]      stall_cycles
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic        e_hit, m_hit;
    logic        lu_stall, br_stall, hl_stall, stall;
    logic        md_pending;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    mdu_seq #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_mdu (
        .clk         (clk),
        .rst         (rst),
        .md_start_i  (e_md_start),
        .md_div_i    (e_md_div),
        .md_busy_o   (md_busy),
        .md_done_o   (md_done),
        .md_pending_o(md_pending)
    );

    // $0 is hard-wired, so a write to it never creates a dependency.
    always_comb begin
        e_hit = (e_wreg != REG_ZERO) &&
                ((d_use_rs && (d_rs == e_wreg)) || (d_use_rt && (d_rt == e_wreg)));
        m_hit = (m_wreg != REG_ZERO) &&
                ((d_use_rs && (d_rs == m_wreg)) || (d_use_rt && (d_rt == m_wreg)));

        lu_stall = e_memread && e_regwrite && e_hit;
        br_stall = d_is_branch && ((e_regwrite && e_hit) || (m_memread && m_hit));
        hl_stall = d_use_hilo && (e_md_start || md_pending);
        stall    = lu_stall || br_stall || hl_stall;

        // The redirect must win so the PC can load the handler address.
        nostall  = ex_flush || !stall;
        e_bubble = ex_flush || stall;
        d_flush  = ex_flush;

        stall_cnt_d = (stall && !ex_flush) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule
